timebase_gen: RTL and testbench
===============================

# timebase_gen

Multi-channel programmable timebase that produces single-cycle clock-enable ticks on the CPU clock. It generalises the fixed compile-time CPU, peripheral, RTC and baud dividers into N independently programmable channels. Each channel has its own run-time divisor, enable and optional fractional correction, and all channels can be phase-aligned on request. It sits beside the CLINT and UART and feeds them tick enables, so no derived clocks are needed.

## Interface
- `CHANNELS`, 4 — number of independent tick channels (1–16).
- `CNT_WIDTH`, 16 — width of divisor and counter.
- `FRAC_WIDTH`, 8 — width of fractional divisor and accumulator (used only with the macro).
- `DIV_RESET`, 25 — divisor loaded into every channel at reset.
- `clock` in 1 — CPU clock.
- `reset` in 1 — synchronous, active-high.
- `cfg_valid` in 1 — write strobe; sampled on the rising edge, no backpressure.
- `cfg_chan` in $clog2(CHANNELS) — target channel for a write or a readback.
- `cfg_en` in 1 — channel enable written with the strobe.
- `cfg_div` in CNT_WIDTH — integer divisor written with the strobe.
- `cfg_frac` in FRAC_WIDTH — fractional divisor written with the strobe.
- `sync` in 1 — phase-align all enabled channels.
- `tick` out CHANNELS — registered one-cycle tick per channel.
- `cfg_rdata` out CNT_WIDTH — registered divisor of channel `cfg_chan`.

## Operation
- Per-channel state:
  - `en`, reset 0.
  - `div`, reset `DIV_RESET`.
  - `frac`, reset 0.
  - `cnt`, reset 0.
  - `acc`, reset 0.
- Effective divisor `d` = max(`div`, 1); a divisor of 0 behaves as 1.
- Enabled channel, each edge:
  - If `cnt`==0: `tick`<=1 and `cnt`<=`d`-1.
  - Otherwise: `tick`<=0 and `cnt`<=`cnt`-1.
- Disabled channel: `tick`<=0 and `cnt` holds.
- Write to a disabled channel whose `cfg_en`=1:
  - `div`/`frac` update.
  - `cnt`<=new `d`-1 and `acc`<=0 in the same edge (immediate start).
- Write to an enabled channel with `cfg_en`=1:
  - `div`/`frac` update immediately.
  - The running `cnt` is untouched, so the new period takes effect at the next reload (glitch-free).
- Write with `cfg_en`=0: channel stops and `tick`<=0 on that edge; the registers still update.
- `sync`=1: every enabled channel gets `cnt`<=`d`-1, `acc`<=0 and `tick`<=0, overriding any reload that edge.
- `sync` and a write on the same edge: the write's new divisor and enable apply, and the `sync` reload uses the new `d`.
- `cfg_rdata`<=`div[cfg_chan]` every edge; reset value 0.
- Reset mid-count: all state returns to its reset values; no tick is emitted on the reset edge.

## Timing
- Write enabling a channel at edge k: `tick` is high in the cycles after edges k+d, k+2d, and so on; the period is exactly d cycles.
- `d`=1: `tick` is high continuously from edge k+1.
- Tick is always a single-cycle pulse except when `d`=1.
- `cfg_rdata` latency: 1 cycle; a write at edge k is visible after edge k+1.
- Reset values: `tick`=0, `cfg_rdata`=0.
- Arithmetic:
  - `cnt` and `div` are unsigned CNT_WIDTH.
  - `d`-1 never underflows because `d`≥1.
  - `acc` wraps modulo 2^FRAC_WIDTH; the carry is used, never saturated.

## Configuration
- `TIMEBASE_FRAC_EN`:
  - Defined: on each reload, `acc`<=`acc`+`frac`. On carry-out the reload value is `d` instead of `d`-1, so that period is d+1.
  - Result: long-run average period d + frac/2^FRAC_WIDTH. Example: 25 MHz/115200 uses `div`=217, `frac`=4.
  - Undefined: `frac` and `acc` are not implemented. `cfg_frac` is ignored and every period is exactly d.

## Test plan
- Reset, then enable ch0 with `div`=5 -> ticks at edges k+5, k+10, k+15; `cfg_rdata` for ch0 reads 5 one cycle after the write.
- Enable ch1 with `div`=0 and with `div`=1 -> `tick[1]` high every cycle from k+1 in both cases.
- ch0 running with `div`=8; write `div`=3 mid-period -> the current 8-cycle period completes, then 3-cycle periods follow.
- ch0 (`div`=4) and ch2 (`div`=6) running out of phase; pulse `sync` -> both tick 4 and 6 cycles after the sync edge and coincide every 12 cycles.
- Write `cfg_en`=0 to ch3 while a tick is due -> no tick; re-enable with `div`=2 -> first tick 2 cycles later. Assert `reset` mid-count -> all outputs 0.
- With `TIMEBASE_FRAC_EN`: `div`=217, `frac`=128 -> periods alternate 217/218, giving 435 cycles per 2 ticks. Without the macro: `div`=217, `frac`=128 -> every period is exactly 217.

Source files
------------

// File: rtl/timebase_gen.sv
// timebase_gen: N-channel programmable tick-enable generator; fractional correction enabled by TIMEBASE_FRAC_EN
module timebase_gen #(
  parameter int CHANNELS = 4,
  parameter int CNT_WIDTH = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int DIV_RESET = 25,
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cfg_valid,
  input  logic [CW-1:0]         cfg_chan,
  input  logic                  cfg_en,
  input  logic [CNT_WIDTH-1:0]  cfg_div,
  input  logic [FRAC_WIDTH-1:0] cfg_frac,
  input  logic                  sync,
  output logic [CHANNELS-1:0]   tick,
  output logic [CNT_WIDTH-1:0]  cfg_rdata
);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
  logic [CHANNELS-1:0][CNT_WIDTH-1:0] div_all;
`ifndef TIMEBASE_FRAC_EN
  logic [FRAC_WIDTH-1:0] unused_frac;
  assign unused_frac = cfg_frac;
`endif
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic en, t, hit, en_n, restart;
    logic [CNT_WIDTH-1:0] div, cnt, div_n, d_n, d_c, rl;
    assign hit = cfg_valid && cfg_chan == CW'(i);
    assign en_n = hit ? cfg_en : en;
    assign div_n = hit ? cfg_div : div;
    assign d_n = div_n == '0 ? ONE : div_n;
    assign d_c = div == '0 ? ONE : div;
    assign restart = en_n && (sync || !en);
`ifdef TIMEBASE_FRAC_EN
    logic [FRAC_WIDTH-1:0] frac, acc;
    logic [FRAC_WIDTH:0] sum;
    assign sum = {1'b0, acc} + {1'b0, frac};
    assign rl = sum[FRAC_WIDTH] ? d_c : d_c - ONE;
    // fractional accumulator: cleared on start/sync, advanced by frac on every reload
    always_ff @(posedge clock) begin
      if (reset) begin
        frac <= '0;
        acc <= '0;
      end else begin
        if (hit) frac <= cfg_frac;
        if (restart) acc <= '0;
        else if (en_n && cnt == '0) acc <= sum[FRAC_WIDTH-1:0];
      end
    end
`else
    assign rl = d_c - ONE;
`endif
    // channel counter: restart on enable or sync, otherwise count down and tick on reload
    always_ff @(posedge clock) begin
      if (reset) begin
        en <= 1'b0;
        div <= CNT_WIDTH'(DIV_RESET);
        cnt <= '0;
        t <= 1'b0;
      end else begin
        en <= en_n;
        div <= div_n;
        t <= en_n && en && !sync && cnt == '0;
        if (restart) cnt <= d_n - ONE;
        else if (en_n) cnt <= cnt == '0 ? rl : cnt - ONE;
      end
    end
    assign tick[i] = t;
    assign div_all[i] = div;
  end
  // divisor readback, one cycle behind the selected channel's register
  always_ff @(posedge clock) begin
    if (reset) cfg_rdata <= '0;
    else cfg_rdata <= {1'b0, cfg_chan} < (CW + 1)'(CHANNELS) ? div_all[cfg_chan] : '0;
  end
endmodule

// File: tb/tb_timebase_gen.sv
// tb_timebase_gen: scoreboard bench predicting tick cycles per channel for timebase_gen
module tb_timebase_gen;
  logic clock = 0, reset = 1, cfg_valid = 0, cfg_en = 0, sync = 0;
  logic [1:0] cfg_chan = 0;
  logic [15:0] cfg_div = 0;
  logic [7:0] cfg_frac = 0;
  logic [3:0] tick;
  logic [15:0] cfg_rdata;
  int cyc = 0, total = 0, bad = 0;
  int q[4][$];

  timebase_gen dut (
    .clock(clock), .reset(reset), .cfg_valid(cfg_valid), .cfg_chan(cfg_chan),
    .cfg_en(cfg_en), .cfg_div(cfg_div), .cfg_frac(cfg_frac), .sync(sync),
    .tick(tick), .cfg_rdata(cfg_rdata)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic cycle();
    int e;
    @(negedge clock);
    for (int c = 0; c < 4; c++) begin
      if (tick[c] === 1'b1) begin
        total++;
        if (q[c].size() == 0) begin
          bad++;
          $display("FAIL tick_ch%0d unexpected tick at cycle %0d, none required", c, cyc);
        end else begin
          e = q[c].pop_front();
          if (cyc !== e) begin
            bad++;
            $display("FAIL tick_ch%0d got tick at cycle %0d, required at %0d", c, cyc, e);
          end
        end
      end
    end
  endtask

  task automatic run_to(input int t);
    while (cyc < t) cycle();
  endtask

  task automatic wr(input int ch, input bit en, input int dv, input int fr, output int k);
    cfg_valid = 1;
    cfg_chan = ch[1:0];
    cfg_en = en;
    cfg_div = dv[15:0];
    cfg_frac = fr[7:0];
    k = cyc + 1;
    cycle();
    cfg_valid = 0;
  endtask

  task automatic end_check(input string name);
    for (int c = 0; c < 4; c++) begin
      total++;
      if (q[c].size() != 0) begin
        bad++;
        $display("FAIL %s_ch%0d missing ticks: pending=%0d first required cycle=%0d", name, c, q[c].size(), q[c][0]);
        q[c].delete();
      end
    end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) cycle();
    total++;
    if (tick !== 4'b0) begin bad++; $display("FAIL reset_tick got %b required 0000", tick); end
    total++;
    if (cfg_rdata !== 16'd0) begin bad++; $display("FAIL reset_rdata got %0d required 0", cfg_rdata); end
    reset = 0;
    cycle();
    total++;
    if (cfg_rdata !== 16'd25) begin bad++; $display("FAIL reset_div got %0d required 25", cfg_rdata); end
  endtask

  task automatic test_basic();
    int k, k2;
    wr(0, 1, 5, 0, k);
    for (int j = 1; j <= 3; j++) q[0].push_back(k + 5 * j);
    total++;
    if (cfg_rdata !== 16'd25) begin bad++; $display("FAIL rdata_before got %0d required 25", cfg_rdata); end
    cycle();
    total++;
    if (cfg_rdata !== 16'd5) begin bad++; $display("FAIL rdata_after got %0d required 5", cfg_rdata); end
    run_to(k + 15);
    wr(0, 0, 5, 0, k2);
    run_to(k + 22);
    end_check("basic");
  endtask

  task automatic test_div01();
    int k, k2;
    wr(1, 1, 0, 0, k);
    for (int j = 1; j <= 6; j++) q[1].push_back(k + j);
    run_to(k + 6);
    wr(1, 0, 0, 0, k2);
    repeat (2) cycle();
    wr(1, 1, 1, 0, k);
    for (int j = 1; j <= 6; j++) q[1].push_back(k + j);
    run_to(k + 6);
    wr(1, 0, 1, 0, k2);
    run_to(k2 + 3);
    end_check("div01");
  endtask

  task automatic test_change();
    int k, k2;
    wr(0, 1, 8, 0, k);
    q[0].push_back(k + 8);
    run_to(k + 3);
    wr(0, 1, 3, 0, k2);
    q[0].push_back(k + 11);
    q[0].push_back(k + 14);
    run_to(k + 14);
    wr(0, 0, 3, 0, k2);
    run_to(k + 20);
    end_check("change");
  endtask

  task automatic test_sync();
    int k, k2, s;
    wr(0, 1, 4, 0, k);
    q[0].push_back(k + 4);
    cycle();
    wr(2, 1, 6, 0, k2);
    run_to(k + 5);
    sync = 1;
    s = cyc + 1;
    cycle();
    sync = 0;
    for (int j = 1; j <= 3; j++) q[0].push_back(s + 4 * j);
    q[2].push_back(s + 6);
    q[2].push_back(s + 12);
    run_to(s + 12);
    total++;
    if (tick[0] !== 1'b1 || tick[2] !== 1'b1) begin
      bad++;
      $display("FAIL sync_coincide got %b required ch0 and ch2 high", tick);
    end
    wr(0, 0, 4, 0, k2);
    wr(2, 0, 6, 0, k2);
    run_to(s + 20);
    end_check("sync");
  endtask

  task automatic test_disable_due();
    int k, k2;
    wr(3, 1, 3, 0, k);
    q[3].push_back(k + 3);
    run_to(k + 5);
    wr(3, 0, 3, 0, k2);
    run_to(k + 10);
    wr(3, 1, 2, 0, k);
    q[3].push_back(k + 2);
    run_to(k + 3);
    reset = 1;
    cycle();
    total++;
    if (tick !== 4'b0) begin bad++; $display("FAIL midreset_tick got %b required 0000", tick); end
    total++;
    if (cfg_rdata !== 16'd0) begin bad++; $display("FAIL midreset_rdata got %0d required 0", cfg_rdata); end
    reset = 0;
    repeat (4) cycle();
    total++;
    if (cfg_rdata !== 16'd25) begin bad++; $display("FAIL midreset_div got %0d required 25", cfg_rdata); end
    end_check("disable");
  endtask

  task automatic test_frac();
    int k, k2, last;
    wr(0, 1, 217, 128, k);
`ifdef TIMEBASE_FRAC_EN
    q[0].push_back(k + 217);
    q[0].push_back(k + 434);
    q[0].push_back(k + 652);
    q[0].push_back(k + 869);
    last = k + 869;
`else
    for (int j = 1; j <= 4; j++) q[0].push_back(k + 217 * j);
    last = k + 868;
`endif
    run_to(last);
    wr(0, 0, 217, 128, k2);
    run_to(last + 10);
    end_check("frac");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div01();
    test_change();
    test_sync();
    test_disable_due();
    test_frac();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
